// File: rtl/segway_pkg.sv
// Shared Segway types and constants: round-robin channel enum, default ADC channel map, ADC command helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package segway_pkg;

    localparam int A2D_CMD_W = 16;

    // Default ADC128S channel assignment on the Segway board
    localparam logic [2:0] CH_LFT_DFLT  = 3'd0;
    localparam logic [2:0] CH_RGHT_DFLT = 3'd4;
    localparam logic [2:0] CH_BATT_DFLT = 3'd5;

    // Round-robin slot; encoding 2'b11 is never produced and is treated as LFT
    typedef enum logic [1:0] {
        RR_LFT  = 2'd0,
        RR_RGHT = 2'd1,
        RR_BATT = 2'd2
    } rr_ch_t;

    function automatic rr_ch_t rr_next(input rr_ch_t cur);
        rr_ch_t nxt_ch;
        case (cur)
            RR_LFT:  nxt_ch = RR_RGHT;
            RR_RGHT: nxt_ch = RR_BATT;
            default: nxt_ch = RR_LFT;
        endcase
        return nxt_ch;
    endfunction

    // ADC128S control word: channel address sits in bits [13:11]
    function automatic logic [A2D_CMD_W-1:0] a2d_cmd(input logic [2:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

endpackage

// File: rtl/spi_mnrch16.sv
// Generic 16-bit SPI master (mode 3: SCLK idles high, MOSI changes on fall, MISO sampled on rise).
// Latency: wrt -> done = 16*2**SCLK_DIV_W + 2**(SCLK_DIV_W-1) clk (front porch, 16 bits, back porch).
// Backpressure: wrt is only accepted while idle; wrt during a frame is ignored.
// Ports: clk/rst_n; wrt + wt_data start a frame; done pulses 1 clk with rd_data valid;
//        SS_n/SCLK/MOSI/MISO are the serial pins.
module spi_mnrch16 #(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    // Every phase lasts half an SCLK period
    localparam int HW = SCLK_DIV_W - 1;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_PORCH,
        SPI_LOW,
        SPI_HIGH,
        SPI_BACK
    } spi_st_t;

    spi_st_t       st_q, st_d;
    logic [HW-1:0] div_q, div_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   tx_q, tx_d;
    logic [15:0]   rx_q, rx_d;
    logic          ss_n_q, ss_n_d;
    logic          sclk_q, sclk_d;
    logic          done_q, done_d;
    logic          half_end;

    assign half_end = (div_q == {HW{1'b1}});

    always_comb begin
        st_d      = st_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        ss_n_d    = ss_n_q;
        sclk_d    = sclk_q;
        done_d    = 1'b0;
        if (st_q != SPI_IDLE) begin
            div_d = div_q + 1'b1;
        end
        case (st_q)
            SPI_IDLE: begin
                if (wrt) begin
                    ss_n_d    = 1'b0;
                    tx_d      = wt_data;
                    div_d     = '0;
                    bit_cnt_d = '0;
                    st_d      = SPI_PORCH;
                end
            end
            SPI_PORCH: begin
                // First fall: bit 15 is already on MOSI, so no shift here
                if (half_end) begin
                    sclk_d = 1'b0;
                    st_d   = SPI_LOW;
                end
            end
            SPI_LOW: begin
                if (half_end) begin
                    sclk_d    = 1'b1;
                    rx_d      = {rx_q[14:0], MISO};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    st_d      = (bit_cnt_q == 4'd15) ? SPI_BACK : SPI_HIGH;
                end
            end
            SPI_HIGH: begin
                if (half_end) begin
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[14:0], 1'b0};
                    st_d   = SPI_LOW;
                end
            end
            SPI_BACK: begin
                // SCLK already high after the 16th rise; hold half a period then release SS_n
                if (half_end) begin
                    ss_n_d = 1'b1;
                    done_d = 1'b1;
                    st_d   = SPI_IDLE;
                end
            end
            default: begin
                ss_n_d = 1'b1;
                sclk_d = 1'b1;
                st_d   = SPI_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= SPI_IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            ss_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            ss_n_q    <= ss_n_d;
            sclk_q    <= sclk_d;
            done_q    <= done_d;
        end
    end

    assign done    = done_q;
    assign rd_data = rx_q;
    assign SS_n    = ss_n_q;
    assign SCLK    = sclk_q;
    assign MOSI    = ss_n_q ? 1'b0 : tx_q[15];

endmodule

// File: rtl/a2d_rr_sampler.sv
// Round-robin ADC128S sampler: each nxt converts lft -> rght -> batt via a command frame then a read frame.
// Latency: nxt -> smpl_vld about 2 SPI frames + 3 clk (~1060 clk at SCLK_DIV_W=5).
// Backpressure: none; nxt outside IDLE (including the READ done clk) is dropped, never queued.
// Ports: clk/rst_n; nxt request; lft_ld/rght_ld/batt holding registers with smpl_vld update pulse;
//        SS_n/SCLK/MOSI/MISO to the ADC.
module a2d_rr_sampler
    import segway_pkg::*;
#(
    parameter int         SCLK_DIV_W = 5,
    parameter logic [2:0] CH_LFT     = CH_LFT_DFLT,
    parameter logic [2:0] CH_RGHT    = CH_RGHT_DFLT,
    parameter logic [2:0] CH_BATT    = CH_BATT_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        smpl_vld,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_GAP,
        ST_READ
    } a2d_st_t;

    a2d_st_t              st_q, st_d;
    rr_ch_t               ptr_q, ptr_d;
    logic [11:0]          lft_q, lft_d;
    logic [11:0]          rght_q, rght_d;
    logic [11:0]          batt_q, batt_d;
    logic                 smpl_vld_q, smpl_vld_d;
    logic                 wrt;
    logic [2:0]           chnl;
    logic [A2D_CMD_W-1:0] cmd;
    logic                 done;
    logic [15:0]          rd_data;
    logic [3:0]           rx_hi_unused;

    // The ADC returns the result of the channel addressed in the previous frame,
    // so the read frame re-sends the same command word.
    always_comb begin
        case (ptr_q)
            RR_RGHT: chnl = CH_RGHT;
            RR_BATT: chnl = CH_BATT;
            default: chnl = CH_LFT;
        endcase
    end

    assign cmd          = a2d_cmd(chnl);
    assign rx_hi_unused = rd_data[15:12];

    always_comb begin
        st_d       = st_q;
        ptr_d      = ptr_q;
        lft_d      = lft_q;
        rght_d     = rght_q;
        batt_d     = batt_q;
        smpl_vld_d = 1'b0;
        wrt        = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (nxt) begin
                    wrt  = 1'b1;
                    st_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (done) begin
                    st_d = ST_GAP;
                end
            end
            ST_GAP: begin
                wrt  = 1'b1;
                st_d = ST_READ;
            end
            ST_READ: begin
                if (done) begin
                    case (ptr_q)
                        RR_RGHT: rght_d = rd_data[11:0];
                        RR_BATT: batt_d = rd_data[11:0];
                        default: lft_d  = rd_data[11:0];
                    endcase
                    smpl_vld_d = 1'b1;
                    ptr_d      = rr_next(ptr_q);
                    st_d       = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_IDLE;
            ptr_q      <= RR_LFT;
            lft_q      <= 12'h000;
            rght_q     <= 12'h000;
            batt_q     <= 12'h000;
            smpl_vld_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            ptr_q      <= ptr_d;
            lft_q      <= lft_d;
            rght_q     <= rght_d;
            batt_q     <= batt_d;
            smpl_vld_q <= smpl_vld_d;
        end
    end

    spi_mnrch16 #(
        .SCLK_DIV_W (SCLK_DIV_W)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .wt_data (cmd),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    assign lft_ld   = lft_q;
    assign rght_ld  = rght_q;
    assign batt     = batt_q;
    assign smpl_vld = smpl_vld_q;

endmodule

// File: tb/tb_a2d_rr_sampler.sv
// Directed bench for a2d_rr_sampler with a behavioural ADC128S and scoreboards for readings and commands.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_a2d_rr_sampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        MISO = 1'b0;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        smpl_vld, SS_n, SCLK, MOSI;

    always #5 clk = ~clk;

    a2d_rr_sampler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .nxt      (nxt),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .batt     (batt),
        .smpl_vld (smpl_vld),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    typedef struct {
        logic [11:0] l;
        logic [11:0] r;
        logic [11:0] b;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] cmd_q[$];

    // ---------------- ADC128S model ----------------
    logic [11:0] adc_val [8];
    logic [2:0]  adc_addr = 3'd0;
    logic [15:0] adc_tx = '0;
    logic [15:0] mosi_sr = '0;
    int          rise_cnt = 0;
    int          lo_cnt = 0;
    int          hi_cnt = 0;
    int          sclk_falls = 0;
    int          vld_cnt = 0;

    always @(negedge SS_n) begin
        // cmd_q holds one entry only when the read frame of a pair is starting
        if (rst_n && cmd_q.size() == 1)
            check("gap_hi_clks_1to4", (hi_cnt >= 1 && hi_cnt <= 4), 1);
        rise_cnt = 0;
        lo_cnt   = 0;
        adc_tx   = {4'h0, adc_val[adc_addr]};
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0) begin
            mosi_sr = {mosi_sr[14:0], MOSI};
            rise_cnt++;
        end
    end

    always @(negedge SCLK) begin
        sclk_falls++;
        if (SS_n === 1'b0 && rise_cnt < 16)
            MISO = adc_tx[15 - rise_cnt];
    end

    always @(posedge SS_n) begin
        hi_cnt = 0;
        if (rst_n) begin
            check("rises_per_frame", rise_cnt, 16);
            check("frame_len_528pm2", (lo_cnt >= 526 && lo_cnt <= 530), 1);
            check("frame_expected", (cmd_q.size() != 0), 1);
            if (cmd_q.size() != 0)
                check("mosi_cmd_word", mosi_sr, cmd_q.pop_front());
            adc_addr = mosi_sr[13:11];
        end
    end

    always @(negedge clk) begin
        if (SS_n === 1'b0) lo_cnt++;
        else               hi_cnt++;
    end

    // ---------------- result monitor ----------------
    always @(negedge clk) begin
        if (rst_n && smpl_vld === 1'b1) begin
            exp_t e;
            vld_cnt++;
            check("smpl_vld_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_lft_ld", lft_ld, e.l);
                check("sb_rght_ld", rght_ld, e.r);
                check("sb_batt", batt, e.b);
            end
        end
    end

    // ---------------- stimulus ----------------
    int          tb_ptr = 0;
    logic [11:0] e_l = '0, e_r = '0, e_b = '0;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_nxt();
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    // Accepted conversion: predict both frame commands and the resulting registers
    task automatic convert();
        logic [2:0]  ch;
        logic [15:0] c;
        exp_t        e;
        ch = (tb_ptr == 1) ? 3'd4 : (tb_ptr == 2) ? 3'd5 : 3'd0;
        c  = {2'b00, ch, 11'h000};
        cmd_q.push_back(c);
        cmd_q.push_back(c);
        case (tb_ptr)
            1:       e_r = adc_val[ch];
            2:       e_b = adc_val[ch];
            default: e_l = adc_val[ch];
        endcase
        e.l = e_l;
        e.r = e_r;
        e.b = e_b;
        sb.push_back(e);
        tb_ptr = (tb_ptr + 1) % 3;
        pulse_nxt();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int f0;
        int found;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
        adc_val[0] = 12'h130;
        adc_val[4] = 12'h190;
        adc_val[5] = 12'hC00;

        // 1: reset state and idle quietness
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(2);
        check("rst_lft_ld", lft_ld, 12'h000);
        check("rst_rght_ld", rght_ld, 12'h000);
        check("rst_batt", batt, 12'h000);
        check("rst_smpl_vld", smpl_vld, 1'b0);
        check("rst_SS_n", SS_n, 1'b1);
        check("rst_SCLK", SCLK, 1'b1);
        check("rst_MOSI", MOSI, 1'b0);
        f0 = sclk_falls;
        wait_clk(10000);
        check("idle_sclk_edges", sclk_falls - f0, 0);
        check("idle_SS_n", SS_n, 1'b1);

        // 2/3: one full round, commands and frames checked by the ADC model
        v0 = vld_cnt;
        convert();
        wait_clk(2000);
        check("r1_vld_lft", vld_cnt - v0, 1);
        check("r1_lft_ld", lft_ld, 12'h130);
        v0 = vld_cnt;
        convert();
        wait_clk(2000);
        check("r1_vld_rght", vld_cnt - v0, 1);
        check("r1_rght_ld", rght_ld, 12'h190);
        v0 = vld_cnt;
        convert();
        wait_clk(2000);
        check("r1_vld_batt", vld_cnt - v0, 1);
        check("r1_batt", batt, 12'hC00);

        // 4: second nxt mid-conversion is dropped
        v0 = vld_cnt;
        convert();
        wait_clk(100);
        pulse_nxt();
        wait_clk(1900);
        check("drop_vld_count", vld_cnt - v0, 1);
        check("drop_sb_empty", sb.size(), 0);
        check("drop_cmd_q_empty", cmd_q.size(), 0);

        // 5: new right value, only rght_ld moves (pointer must now be RGHT)
        adc_val[4] = 12'h200;
        convert();
        wait_clk(2000);
        check("r2_rght_ld", rght_ld, 12'h200);
        check("r2_lft_hold", lft_ld, 12'h130);
        check("r2_batt_hold", batt, 12'hC00);
        convert();
        wait_clk(2000);
        check("r2_batt", batt, 12'hC00);

        // 6: reset in the middle of a read frame
        convert();
        found = 0;
        for (int i = 0; i < 1500 && found == 0; i++) begin
            @(negedge clk);
            if (cmd_q.size() == 1 && SS_n === 1'b0) found = 1;
        end
        check("reached_read_frame", found, 1);
        wait_clk(50);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_SS_n", SS_n, 1'b1);
        check("mid_rst_SCLK", SCLK, 1'b1);
        check("mid_rst_lft_ld", lft_ld, 12'h000);
        check("mid_rst_rght_ld", rght_ld, 12'h000);
        check("mid_rst_batt", batt, 12'h000);
        check("mid_rst_smpl_vld", smpl_vld, 1'b0);
        sb.delete();
        cmd_q.delete();
        e_l = '0;
        e_r = '0;
        e_b = '0;
        tb_ptr = 0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        v0 = vld_cnt;
        convert();
        wait_clk(2000);
        check("post_rst_vld", vld_cnt - v0, 1);
        check("post_rst_lft_ld", lft_ld, 12'h130);
        check("post_rst_rght_ld", rght_ld, 12'h000);
        check("post_rst_batt", batt, 12'h000);
        check("post_rst_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
